// File: rtl/traffic_pkg.sv
// Shared types for the intersection scheduler.
//   RED/YELLOW/GREEN : one-hot lamp encodings driven to the lamp drivers
//   phase_t          : scheduler phase enum
//   dir_t            : approach direction (NS/EW)
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } phase_t;

  typedef enum logic {
    NS = 1'b0,
    EW = 1'b1
  } dir_t;

endpackage

// File: rtl/phase_timer.sv
// Phase timer: TW-bit up counter with synchronous clear and saturation.
//   clk   : clock, rising edge
//   reset : synchronous active-high, clears count
//   clear : synchronous clear (asserted on the edge that changes phase)
//   count : cycles spent in the current phase, saturating at 2^TW-1
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic [TW-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (count != '1)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection phase scheduler (Moore FSM + one phase timer).
// Optional pedestrian walk phase is built when INTERSECTION_PED_EN is defined;
// otherwise pedestrian_button is ignored and walk/ped_pending are tied to 0.
//   clk, reset          : clock, synchronous active-high reset
//   ns_car, ew_car      : vehicle demand levels per approach
//   pedestrian_button   : walk request pulse
//   ns_lights,ew_lights : one-hot lamps (RED=001, YELLOW=010, GREEN=100)
//   walk                : pedestrian walk lamp
//   ped_pending         : latched, unserved walk request
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN   = 6,
  parameter int GREEN_MAX   = 20,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 5,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       pedestrian_button,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic       walk,
  output logic       ped_pending
);

  // Timer reads N-1 during the Nth cycle of a phase, so exits compare to N-1.
  localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_TIME - 1);
`ifdef INTERSECTION_PED_EN
  localparam logic [TW-1:0] WALK_LAST = TW'(WALK_TIME - 1);
`endif

  phase_t        state, state_nx;
  dir_t          next_dir, next_dir_nx;
  logic [TW-1:0] timer;
  logic          own, other, green_exit;

  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_nx != state),
    .count (timer)
  );

  // Demand seen from whichever green is active; a pending walk counts as
  // opposing demand so it can cut a green short after the minimum.
  always_comb begin
    own   = (state == NS_GREEN) ? ns_car : ew_car;
    other = ((state == NS_GREEN) ? ew_car : ns_car) | ped_pending;
    // >= on the max bound: timer may already exceed it if demand arrived late.
    green_exit = (timer >= GMIN_LAST) && other && (!own || timer >= GMAX_LAST);
  end

  always_comb begin
    state_nx    = state;
    next_dir_nx = next_dir;
    case (state)
      ALL_RED: if (timer >= AR_LAST) begin
        state_nx = (next_dir == NS) ? NS_GREEN : EW_GREEN;
`ifdef INTERSECTION_PED_EN
        if (ped_pending) state_nx = PED_WALK;
`endif
      end
      NS_GREEN: if (green_exit) state_nx = NS_YELLOW;
      EW_GREEN: if (green_exit) state_nx = EW_YELLOW;
      NS_YELLOW: if (timer >= YEL_LAST) begin
        state_nx    = ALL_RED;
        next_dir_nx = EW;
      end
      EW_YELLOW: if (timer >= YEL_LAST) begin
        state_nx    = ALL_RED;
        next_dir_nx = NS;
      end
`ifdef INTERSECTION_PED_EN
      // Lamps are already all red, so go straight to the queued green.
      PED_WALK: if (timer >= WALK_LAST)
        state_nx = (next_dir == NS) ? NS_GREEN : EW_GREEN;
`endif
      default: state_nx = ALL_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ALL_RED;
      next_dir <= NS;
    end else begin
      state    <= state_nx;
      next_dir <= next_dir_nx;
    end
  end

`ifdef INTERSECTION_PED_EN
  // Set has priority: a press on the walk entry edge is queued for another walk.
  always_ff @(posedge clk) begin
    if (reset)
      ped_pending <= 1'b0;
    else if (pedestrian_button)
      ped_pending <= 1'b1;
    else if (state_nx == PED_WALK && state != PED_WALK)
      ped_pending <= 1'b0;
  end
`else
  logic unused_button;
  assign unused_button = pedestrian_button;
  assign ped_pending   = 1'b0;
`endif

  always_comb begin
    ns_lights = RED;
    ew_lights = RED;
    walk      = 1'b0;
    case (state)
      NS_GREEN:  ns_lights = GREEN;
      NS_YELLOW: ns_lights = YELLOW;
      EW_GREEN:  ew_lights = GREEN;
      EW_YELLOW: ew_lights = YELLOW;
`ifdef INTERSECTION_PED_EN
      PED_WALK:  walk = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: directed scenarios with
// literal expectations plus randomized demand/button/reset traffic, all
// compared each cycle against a phase-level model with unbounded elapsed time.
module tb_intersection_scheduler;

  localparam int GREEN_MIN = 6, GREEN_MAX = 20, YELLOW_TIME = 3;
  localparam int ALLRED_TIME = 2, WALK_TIME = 5, TW = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic ns_car = 1'b0, ew_car = 1'b0, btn = 1'b0;
  logic [2:0] ns_lights, ew_lights;
  logic walk, ped_pending;

  intersection_scheduler #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_TIME(YELLOW_TIME),
    .ALLRED_TIME(ALLRED_TIME), .WALK_TIME(WALK_TIME), .TW(TW)
  ) dut (
    .clk(clk), .reset(reset), .ns_car(ns_car), .ew_car(ew_car),
    .pedestrian_button(btn), .ns_lights(ns_lights), .ew_lights(ew_lights),
    .walk(walk), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef enum int {M_AR, M_NSG, M_NSY, M_EWG, M_EWY, M_WALK} mph_t;
  mph_t m_ph = M_AR;
  int   m_age = 0;      // full cycles already spent in m_ph (0 in first cycle)
  bit   m_nd_ew = 1'b0; // green that follows all-red / walk
  bit   m_pp = 1'b0;
  bit   m_valid = 1'b0;
  int   cyc = 0;
`ifdef INTERSECTION_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  int vectors = 0, errors = 0;

  always @(posedge clk) begin
    mph_t nxt;
    bit own, oth, nd;
    int spent;
    if (reset) begin
      m_ph <= M_AR; m_age <= 0; m_nd_ew <= 1'b0; m_pp <= 1'b0;
      m_valid <= 1'b1; cyc <= 0;
    end else begin
      spent = m_age + 1;
      nxt = m_ph;
      nd = m_nd_ew;
      own = (m_ph == M_NSG) ? ns_car : ew_car;
      oth = ((m_ph == M_NSG) ? ew_car : ns_car) | m_pp;
      case (m_ph)
        M_AR:   if (spent >= ALLRED_TIME) nxt = m_pp ? M_WALK : (m_nd_ew ? M_EWG : M_NSG);
        M_NSG, M_EWG:
          if (spent >= GREEN_MIN && oth && (!own || spent >= GREEN_MAX))
            nxt = (m_ph == M_NSG) ? M_NSY : M_EWY;
        M_NSY:  if (spent >= YELLOW_TIME) begin nxt = M_AR; nd = 1'b1; end
        M_EWY:  if (spent >= YELLOW_TIME) begin nxt = M_AR; nd = 1'b0; end
        M_WALK: if (spent >= WALK_TIME) nxt = m_nd_ew ? M_EWG : M_NSG;
        default: nxt = M_AR;
      endcase
      if (PED)
        m_pp <= btn | (m_pp & !(nxt == M_WALK && m_ph != M_WALK));
      m_age   <= (nxt == m_ph) ? m_age + 1 : 0;
      m_ph    <= nxt;
      m_nd_ew <= nd;
      cyc     <= cyc + 1;
    end
  end

  function automatic logic [2:0] lamp_ns(mph_t p);
    return (p == M_NSG) ? 3'b100 : (p == M_NSY) ? 3'b010 : 3'b001;
  endfunction
  function automatic logic [2:0] lamp_ew(mph_t p);
    return (p == M_EWG) ? 3'b100 : (p == M_EWY) ? 3'b010 : 3'b001;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d t=%0t got %0h want %0h", nm, cyc, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ns_lights", ns_lights, lamp_ns(m_ph));
      chk("ew_lights", ew_lights, lamp_ew(m_ph));
      chk("walk", walk, (m_ph == M_WALK));
      chk("ped_pending", ped_pending, m_pp);
      chk("exclusive", (ns_lights != 3'b001) && (ew_lights != 3'b001), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic rst();
    @(negedge clk);
    reset = 1'b1; ns_car = 1'b0; ew_car = 1'b0; btn = 1'b0;
    @(negedge clk);
    reset = 1'b0;  // now in cycle 0
  endtask

  task automatic to(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != c) begin
      errors++;
      $display("FAIL timeout waiting for cyc %0d (at %0d)", c, cyc);
    end
  endtask

  initial begin
    // 1: idle after reset, NS green forever, timer saturates without wrap
    rst();
    chk("s1_ns_c0", ns_lights, 3'b001); chk("s1_ew_c0", ew_lights, 3'b001);
    chk("s1_walk_c0", walk, 0);
    to(1);   chk("s1_ns_c1", ns_lights, 3'b001);
    to(2);   chk("s1_ns_c2", ns_lights, 3'b100); chk("s1_ew_c2", ew_lights, 3'b001);
    to(35);  chk("s1_ns_c35", ns_lights, 3'b100);
    to(300); ew_car = 1'b1;
    to(301); chk("s1_sat_yellow", ns_lights, 3'b010);

    // 2: EW demand at cycle 10
    rst();
    to(10);  ew_car = 1'b1;
    to(11);  chk("s2_ns_c11", ns_lights, 3'b010);
    to(13);  chk("s2_ns_c13", ns_lights, 3'b010);
    to(14);  chk("s2_ns_c14", ns_lights, 3'b001); chk("s2_ew_c14", ew_lights, 3'b001);
    to(15);  chk("s2_ew_c15", ew_lights, 3'b001);
    to(16);  chk("s2_ew_c16", ew_lights, 3'b100);

    // 3: both cars continuously -> max green
    rst();
    ns_car = 1'b1; ew_car = 1'b1;
    to(21);  chk("s3_ns_c21", ns_lights, 3'b100);
    to(22);  chk("s3_ns_c22", ns_lights, 3'b010);
    to(24);  chk("s3_ns_c24", ns_lights, 3'b010);
    to(25);  chk("s3_ns_c25", ns_lights, 3'b001); chk("s3_ew_c25", ew_lights, 3'b001);
    to(27);  chk("s3_ew_c27", ew_lights, 3'b100);

    // 4/5: button pulse at cycle 5, then a press on the walk entry edge
    rst();
    to(5);   btn = 1'b1;
    to(6);   btn = 1'b0;
    if (PED) begin
      chk("s4_pp_c6", ped_pending, 1);
      to(8);  chk("s4_ns_c8", ns_lights, 3'b010);
      to(11); chk("s4_ns_c11", ns_lights, 3'b001);
    end
    to(12);  btn = 1'b1;
    to(13);  btn = 1'b0;
    if (PED) begin
      chk("s4_walk_c13", walk, 1); chk("s5_pp_c13", ped_pending, 1);
      to(17); chk("s4_walk_c17", walk, 1);
      to(18); chk("s4_walk_c18", walk, 0); chk("s4_ew_c18", ew_lights, 3'b100);
      to(29); chk("s5_walk_c29", walk, 1);
    end else begin
      chk("s4_nowalk_c13", walk, 0); chk("s4_ns_c13", ns_lights, 3'b100);
      to(29); chk("s5_ns_c29", ns_lights, 3'b100);
    end

    // 6: reset during EW yellow
    rst();
    ew_car = 1'b1;
    to(13);  chk("s6_ew_c13", ew_lights, 3'b100);
    ns_car = 1'b1; ew_car = 1'b0;
    to(19);  chk("s6_ew_c19", ew_lights, 3'b010);
    reset = 1'b1;
    @(negedge clk);
    chk("s6_ns_rst", ns_lights, 3'b001); chk("s6_ew_rst", ew_lights, 3'b001);
    chk("s6_walk_rst", walk, 0);
    reset = 1'b0;
    to(1);   chk("s6_ns_c1", ns_lights, 3'b001);
    to(2);   chk("s6_ns_c2", ns_lights, 3'b100);

    // random traffic
    rst();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) ns_car = ~ns_car;
      if ($urandom_range(0, 7) == 0) ew_car = ~ew_car;
      btn   = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
